// File: rtl/telemetry_frame_packer_pkg.sv
// Shared constants, event bit positions and FSM state type for the
// telemetry frame packer and its byte selector.
package telemetry_pkg;
    localparam logic [7:0] SOF_BYTE = 8'hA5;

    localparam int EV_COORD = 0;
    localparam int EV_LIGHT = 1;
    localparam int EV_CAR   = 2;
    localparam int EV_HUMAN = 3;
    localparam int EV_SEC   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_TYPE,
        ST_BODY,
        ST_CHK
    } state_e;

    // SOF + TYPE + 8 coordinate bytes per ROI + red + green + STATUS + CHK.
    function automatic int frame_len(input int num_roi);
        return 6 + 8 * num_roi;
    endfunction
endpackage

// File: rtl/telemetry_frame_packer_frame_byte_mux.sv
// Selects one body byte of the frame (coordinates, timers, status) from the
// registered snapshot, given its index within the body.
module frame_byte_mux #(
    parameter int NUM_ROI = 1,
    parameter int COORD_W = 10,
    parameter int TIME_W  = 5,
    parameter int IDX_W   = 4
) (
    input  logic [NUM_ROI*4*COORD_W-1:0] roi_coords,
    input  logic [TIME_W-1:0]            red_time,
    input  logic [TIME_W-1:0]            green_time,
    input  logic [7:0]                   status,
    input  logic [IDX_W-1:0]             body_idx,
    output logic [7:0]                   body_byte
);
    localparam int NUM_COORDS  = NUM_ROI * 4;
    localparam int COORD_BYTES = 2 * NUM_COORDS;

    logic [15:0] coord_ext;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        coord_ext = '0;
        for (int c = 0; c < NUM_COORDS; c++) begin
            if ((int'(body_idx) >> 1) == c) begin
                coord_ext = 16'(roi_coords[c*COORD_W +: COORD_W]);
            end
        end

        body_byte = 8'h00;
        // Even index carries the high byte of a coordinate, odd index the low byte.
        if (int'(body_idx) < COORD_BYTES) begin
            body_byte = body_idx[0] ? coord_ext[7:0] : coord_ext[15:8];
        end else if (int'(body_idx) == COORD_BYTES) begin
            body_byte = 8'(red_time);
        end else if (int'(body_idx) == COORD_BYTES + 1) begin
            body_byte = 8'(green_time);
        end else if (int'(body_idx) == COORD_BYTES + 2) begin
            body_byte = status;
        end
    end
endmodule

// File: rtl/telemetry_frame_packer.sv
// Snapshots intersection telemetry on event ticks and streams it as a framed,
// XOR-checksummed byte sequence over valid/ready; events during a frame coalesce.
module telemetry_frame_packer
    import telemetry_pkg::*;
#(
    parameter int         NUM_ROI  = 1,
    parameter int         COORD_W  = 10,
    parameter int         TIME_W   = 5,
    parameter logic [4:0] EVENT_EN = 5'b11111
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_coord,
    input  logic                         ev_light,
    input  logic                         ev_warn_car,
    input  logic                         ev_warn_human,
    input  logic                         ev_sec,
    input  logic [NUM_ROI*4*COORD_W-1:0] roi_coords,
    input  logic [TIME_W-1:0]            red_left_time,
    input  logic [TIME_W-1:0]            green_left_time,
    input  logic                         traffic_light,
    input  logic                         traffic_amount,
    input  logic                         warn_car,
    input  logic                         warn_human,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic [15:0]                  frames_sent,
    output logic [7:0]                   coalesced_cnt
);
    localparam int ROI_W    = NUM_ROI * 4 * COORD_W;
    localparam int LAST_IDX = frame_len(NUM_ROI) - 4;
    localparam int IDX_W    = $clog2(LAST_IDX + 2);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   body_idx_q, body_idx_d, mux_idx;
    logic [7:0]         tx_data_q, tx_data_d, mux_byte;
    logic               tx_valid_q, tx_valid_d, busy_q, busy_d;
    logic               pending_q, pending_d;
    logic [4:0]         ev_acc_q, ev_acc_d, ev_vec;
    logic [7:0]         snap_type_q, snap_type_d, snap_status_q, snap_status_d;
    logic [ROI_W-1:0]   snap_roi_q, snap_roi_d;
    logic [TIME_W-1:0]  snap_red_q, snap_red_d, snap_green_q, snap_green_d;
    logic [7:0]         chk_q, chk_d, coal_q, coal_d;
    logic [15:0]        frames_q, frames_d;
    logic               trigger, accept, do_snap;

    always_comb begin
        ev_vec           = '0;
        ev_vec[EV_COORD] = ev_coord;
        ev_vec[EV_LIGHT] = ev_light;
        ev_vec[EV_CAR]   = ev_warn_car;
        ev_vec[EV_HUMAN] = ev_warn_human;
        ev_vec[EV_SEC]   = ev_sec;
    end

    assign trigger = |(ev_vec & EVENT_EN);
    assign accept  = tx_valid_q && tx_ready;
    assign mux_idx = (state_q == ST_TYPE) ? '0 : body_idx_q + IDX_W'(1);

    frame_byte_mux #(
        .NUM_ROI (NUM_ROI),
        .COORD_W (COORD_W),
        .TIME_W  (TIME_W),
        .IDX_W   (IDX_W)
    ) u_byte_mux (
        .roi_coords (snap_roi_q),
        .red_time   (snap_red_q),
        .green_time (snap_green_q),
        .status     (snap_status_q),
        .body_idx   (mux_idx),
        .body_byte  (mux_byte)
    );

    always_comb begin
        state_d       = state_q;
        body_idx_d    = body_idx_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        pending_d     = pending_q;
        ev_acc_d      = ev_acc_q | ev_vec;
        snap_type_d   = snap_type_q;
        snap_roi_d    = snap_roi_q;
        snap_red_d    = snap_red_q;
        snap_green_d  = snap_green_q;
        snap_status_d = snap_status_q;
        chk_d         = chk_q;
        frames_d      = frames_q;
        coal_d        = coal_q;
        do_snap       = 1'b0;

        if (state_q != ST_IDLE && trigger) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (coal_q != 8'hFF) begin
                coal_d = coal_q + 8'd1;
            end
        end

        case (state_q)
            ST_IDLE: do_snap = trigger;
            ST_SOF: if (accept) begin
                state_d   = ST_TYPE;
                tx_data_d = snap_type_q;
                chk_d     = 8'h00;
            end
            ST_TYPE: if (accept) begin
                state_d    = ST_BODY;
                body_idx_d = '0;
                tx_data_d  = mux_byte;
                chk_d      = chk_q ^ tx_data_q;
            end
            ST_BODY: if (accept) begin
                chk_d = chk_q ^ tx_data_q;
                if (body_idx_q == IDX_W'(LAST_IDX)) begin
                    state_d   = ST_CHK;
                    tx_data_d = chk_q ^ tx_data_q;
                end else begin
                    body_idx_d = body_idx_q + IDX_W'(1);
                    tx_data_d  = mux_byte;
                end
            end
            ST_CHK: if (accept) begin
                frames_d = frames_q + 16'd1;
                // Pending work (or a same-cycle trigger) chains straight into a new frame.
                if (pending_d) begin
                    do_snap = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_snap) begin
            state_d       = ST_SOF;
            tx_data_d     = SOF_BYTE;
            tx_valid_d    = 1'b1;
            pending_d     = 1'b0;
            ev_acc_d      = '0;
            snap_type_d   = {3'b000, ev_acc_q | ev_vec};
            snap_roi_d    = roi_coords;
            snap_red_d    = red_left_time;
            snap_green_d  = green_left_time;
            snap_status_d = {4'b0000, traffic_amount, warn_human, warn_car, traffic_light};
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            body_idx_q    <= '0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            pending_q     <= 1'b0;
            ev_acc_q      <= '0;
            snap_type_q   <= 8'h00;
            snap_roi_q    <= '0;
            snap_red_q    <= '0;
            snap_green_q  <= '0;
            snap_status_q <= 8'h00;
            chk_q         <= 8'h00;
            frames_q      <= 16'h0000;
            coal_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            body_idx_q    <= body_idx_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            busy_q        <= busy_d;
            pending_q     <= pending_d;
            ev_acc_q      <= ev_acc_d;
            snap_type_q   <= snap_type_d;
            snap_roi_q    <= snap_roi_d;
            snap_red_q    <= snap_red_d;
            snap_green_q  <= snap_green_d;
            snap_status_q <= snap_status_d;
            chk_q         <= chk_d;
            frames_q      <= frames_d;
            coal_q        <= coal_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = busy_q;
    assign frames_sent   = frames_q;
    assign coalesced_cnt = coal_q;
endmodule
